// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  // Framing FSM states of the loader.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERR
  } boot_state_t;

  // Bit-level states of the byte receiver.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit qualification at
// half a bit, data sampled at bit centres, stop bit checked at its centre.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_frame_err;

  // Bring the asynchronous line into the clock domain; keep one extra stage
  // so a falling edge can be seen. Idle level is high.
  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what turns these three lines into a shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Bit timing and byte assembly; emits one-cycle valid / framing-error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt        <= '0;
            r_state      <= RX_IDLE;
            r_byte_valid <= r_rx_sync;
            r_frame_err  <= !r_rx_sync;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/LEN/data/CSUM frames, writes instruction
// memory word by word and releases the core once the checksum matches.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int DIV = CLK_FREQ / BAUD;

  logic [7:0]  w_byte_data;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic [15:0] w_len;

  boot_state_t r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic [7:0]  r_csum;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_core_reset;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (w_byte_data),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  assign w_len = {w_byte_data, r_len_lo};

  // Framing FSM with word assembly, address counter, checksum and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          // Sync byte (re)arms a load from address 0 with a fresh checksum.
          if (w_byte_valid && w_byte_data == SYNC_BYTE) begin
            r_state      <= S_LEN_LO;
            r_word_cnt   <= '0;
            r_byte_idx   <= '0;
            r_csum       <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        default: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (w_byte_valid) begin
            case (r_state)
              S_LEN_LO: begin
                r_len_lo <= w_byte_data;
                r_state  <= S_LEN_HI;
              end
              S_LEN_HI: begin
                r_len <= w_len;
                if ({16'd0, w_len} > 32'(IMEM_WORDS)) begin
                  r_state <= S_ERR;
                  r_busy  <= 1'b0;
                  r_error <= 1'b1;
                end else if (w_len == 16'd0) begin
                  r_state <= S_CHECK;
                end else begin
                  r_state <= S_DATA;
                end
              end
              S_DATA: begin
                r_csum <= r_csum + w_byte_data;
                if (r_byte_idx == 2'(WORD_BYTES - 1)) begin
                  // Little-endian: the last byte received is the top byte.
                  r_imem_we    <= 1'b1;
                  r_imem_wdata <= {w_byte_data, r_word};
                  r_imem_addr  <= {14'd0, r_word_cnt, 2'b00};
                  r_word_cnt   <= r_word_cnt + 16'd1;
                  r_byte_idx   <= '0;
                  if (r_word_cnt + 16'd1 == r_len) r_state <= S_CHECK;
                end else begin
                  r_word     <= {w_byte_data, r_word[23:8]};
                  r_byte_idx <= r_byte_idx + 2'd1;
                end
              end
              S_CHECK: begin
                r_busy <= 1'b0;
                if (w_byte_data == r_csum) begin
                  r_state      <= S_RUN;
                  r_core_reset <= 1'b0;
                  r_done       <= 1'b1;
                end else begin
                  r_state <= S_ERR;
                  r_error <= 1'b1;
                end
              end
              default: r_state <= S_ERR;
            endcase
          end
        end
      endcase
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_reset = r_core_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader. Frames are built from byte lists;
// expected writes and final flags come from the frame contents directly.
module tb_uart_boot_loader;

  // Fast baud so the whole run stays short: DIV = 16, the smallest legal divisor.
  localparam int CLK_FREQ   = 1_843_200;
  localparam int BAUD       = 115_200;
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int IMEM_WORDS = 256;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        rx    = 1'b1;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .IMEM_WORDS (IMEM_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks  = 0;
  int          n_errors  = 0;
  wr_t         wr_q[$];
  wr_t         exp_q[$];
  logic [7:0]  data_q[$];
  int          we_double = 0;
  logic        prev_we   = 1'b0;

  // Write monitor: records every imem write and flags strobes wider than one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_q.push_back('{addr: imem_addr, data: imem_wdata});
      if (prev_we) we_double++;
    end
    prev_we <= imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d,
                             input logic e, input logic cr);
    check({tag, "_busy"},       {31'd0, busy},       {31'd0, b});
    check({tag, "_done"},       {31'd0, done},       {31'd0, d});
    check({tag, "_error"},      {31'd0, error},      {31'd0, e});
    check({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, cr});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data%0d", tag, i), wr_q[i].data, exp_q[i].data);
    end
  endtask

  // One 8N1 character; stop level selectable to provoke a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = stop;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
  endtask

  // Random idle gap between characters, including none at all.
  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Sends a whole frame built from data_q and checks writes and final flags.
  task automatic do_load(input string tag, input bit bad_csum, input bit skip_sync);
    int         n_words;
    logic [7:0] sum;
    n_words = data_q.size() / 4;
    sum     = 8'd0;
    exp_q.delete();
    for (int w = 0; w < n_words; w++) begin
      exp_q.push_back('{addr: 32'(w * 4),
                        data: {data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]}});
    end
    foreach (data_q[i]) sum = sum + data_q[i];
    if (bad_csum) sum = sum + 8'd1;
    wr_q.delete();
    if (!skip_sync) begin
      send_byte(8'hA5);
      gap();
    end
    send_byte(8'(n_words));
    gap();
    send_byte(8'(n_words >> 8));
    foreach (data_q[i]) begin
      gap();
      send_byte(data_q[i]);
    end
    gap();
    send_byte(sum);
    settle();
    check_writes(tag);
    check_flags(tag, 1'b0, !bad_csum, bad_csum, bad_csum);
  endtask

  // Hang guard: nothing here waits on a DUT event, but never run forever.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  imem_addr,        32'd0);
    check("rst_wdata", imem_wdata,       32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Good load from the reference frame.
    data_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    do_load("good", 1'b0, 1'b0);
    if (wr_q.size() == 2) begin
      check("good_word0_const", wr_q[0].data, 32'h0050_0013);
      check("good_word1_const", wr_q[1].data, 32'h00A0_0093);
    end else begin
      check("good_wr_count_const", 32'(wr_q.size()), 32'd2);
    end

    // Reload while running: non-sync byte ignored, sync byte re-arms.
    send_byte(8'h55);
    settle();
    check_flags("run_55", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    settle();
    check_flags("run_a5", 1'b1, 1'b0, 1'b0, 1'b1);
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load("reload", 1'b0, 1'b1);

    // Bad checksum: writes still happen, then error.
    data_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    do_load("badsum", 1'b1, 1'b0);

    // Oversize length (257 words), then a good load recovers.
    wr_q.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    settle();
    check("over_wr_count", 32'(wr_q.size()), 32'd0);
    check_flags("over", 1'b0, 1'b0, 1'b1, 1'b1);
    data_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    do_load("after_over", 1'b0, 1'b0);

    // Length exactly at capacity is accepted (aborted by reset afterwards).
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    settle();
    check_flags("len_max", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-word: asynchronous clear of every output.
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    settle();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_we",    {31'd0, imem_we}, 32'd0);
    check("arst_addr",  imem_addr,        32'd0);
    check("arst_wdata", imem_wdata,       32'd0);
    check_flags("arst", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    data_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    do_load("after_rst", 1'b0, 1'b0);

    // Framing error on the second data byte; later bytes must not write.
    wr_q.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    repeat (4) @(posedge clk);
    settle();
    check_flags("ferr", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    settle();
    check("ferr_wr_count", 32'(wr_q.size()), 32'd0);
    check("ferr_error_hold", {31'd0, error}, 32'd1);

    // Zero-length frames: good and bad checksum.
    data_q.delete();
    do_load("len0_good", 1'b0, 1'b0);
    do_load("len0_bad", 1'b1, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 5; n++) begin
      int len;
      len = $urandom_range(0, 4);
      data_q.delete();
      for (int i = 0; i < len * 4; i++) data_q.push_back(8'($urandom));
      do_load($sformatf("rand%0d", n), ($urandom_range(0, 3) == 0), 1'b0);
    end

    check("we_single_cycle", 32'(we_double), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Loads a program into the processor's instruction memory over a UART link, then releases the core from reset. Sits directly upstream of the processor top: it drives the instruction-memory write port and holds the core's active-high reset until a complete, checksum-verified image has been written. A sync byte re-arms loading at any time.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. Divisor `DIV = CLK_FREQ/BAUD` is integer-truncated and must be ≥ 16.
- `IMEM_WORDS`, 256: instruction-memory capacity in 32-bit words.
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx`  in  1: UART receive line, 8N1, LSB first, idle high. Asynchronous to `clk`.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32: byte address of the write. Word-aligned; `[1:0]` is always 0.
- `imem_wdata`  out  32: write data.
- `core_reset`  out  1: active-high reset to the processor. High holds the core.
- `busy`  out  1: a load is in progress.
- `done`  out  1: last load succeeded and the core is running.
- `error`  out  1: last load failed.

## Operation
- Frame format: `0xA5`, `LEN_LO`, `LEN_HI`, then `LEN` words of 4 bytes each (little-endian), then `CSUM`.
  - `CSUM` is the 8-bit modulo-256 sum of all data bytes only.
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A start bit is detected on a falling edge and re-checked low at DIV/2. If it is high there, the receiver ignores it and returns to idle.
  - The 8 data bits are sampled at bit centres.
  - Stop bit high: a one-cycle `byte_valid` pulse.
  - Stop bit low: a one-cycle `frame_err` pulse and no `byte_valid`.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERR.
  - **IDLE** (after reset): a `0xA5` byte goes to LEN_LO. Other bytes and frame errors are ignored.
  - **LEN_LO → LEN_HI → DATA**: each transition consumes one byte.
  - **Length checks after LEN_HI**:
    - `LEN > IMEM_WORDS` goes to ERR.
    - `LEN == 0` goes directly to CHECK.
  - **DATA**:
    - Bytes assemble into a 32-bit word.
    - After the 4th byte, `imem_we` pulses. `imem_addr` starts at 0 for each load and advances by 4 after each write.
    - The checksum accumulates all data bytes.
    - After word LEN, go to CHECK.
  - **CHECK**: the next byte is compared with the accumulated sum.
    - Match goes to RUN.
    - Mismatch goes to ERR. Words already written are not rolled back.
  - **RUN**: `core_reset`=0, `done`=1. A `0xA5` byte reasserts `core_reset`, clears `done`, and goes to LEN_LO. Other bytes are ignored.
  - **ERR**: `error`=1, `core_reset`=1. A `0xA5` byte clears `error` and goes to LEN_LO.
  - **Frame error** in LEN_LO, LEN_HI, DATA or CHECK goes to ERR. In IDLE, RUN or ERR it is ignored.
- `busy`=1 in LEN_LO, LEN_HI, DATA and CHECK.
- `core_reset`=1 in every state except RUN.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `busy`=0, `done`=0, `error`=0. FSM in IDLE, receiver idle, checksum 0.
- Reset asserted mid-load aborts immediately. There is no partial state retention; the next load restarts at address 0.
- All outputs are registered.
- `imem_we`: asserted in the cycle after the 4th byte's `byte_valid`. It lasts exactly 1 cycle, with `imem_addr`/`imem_wdata` stable that cycle.
- State transitions take effect the cycle after `byte_valid` or `frame_err`. `core_reset`, `done` and `error` change in that same cycle.
- `byte_valid` is asserted about DIV/2 cycles after the stop-bit start: sample-at-centre latency plus the 2-cycle synchronizer delay.
- Back-to-back bytes with no idle gap are accepted.
- Minimum spacing between `imem_we` pulses is 40·DIV cycles.

## Structure
- Package `boot_pkg` holds:
  - the state enum `boot_state_t`;
  - the constants `SYNC_BYTE = 8'hA5` and `WORD_BYTES = 4`.
- Sub-module `uart_rx_byte`:
  - parameter `DIV`;
  - ports `clk`, `reset`, `rx`, `byte_data[7:0]`, `byte_valid`, `frame_err`;
  - contains the synchronizer, baud counter and bit counter.
- The top level is the framing FSM, word assembler, address counter and checksum.

## Test plan
All scenarios use DIV=434 and IMEM_WORDS=256.
- **Good load**
  - Stimulus: send A5 02 00 13 00 50 00 93 00 A0 00 96.
  - Required: `imem_we` pulses twice, addr 0 with data 0x00500013 and addr 4 with data 0x00A00093. After the last byte, `core_reset`=0, `done`=1, `busy`=0.
- **Bad checksum**
  - Stimulus: same frame with final byte 97.
  - Required: both writes occur, then `error`=1, `core_reset` stays 1, `done`=0.
- **Oversize length**
  - Stimulus: A5 01 01.
  - Required: `error`=1 after the third byte, no `imem_we`. A following good load clears `error` and succeeds.
- **Reset mid-word**
  - Stimulus: pull `reset` low after A5 01 00 13 00.
  - Required: all outputs at reset values, asynchronously. A subsequent A5 01 00 13 00 00 00 13 writes addr 0 with 0x00000013.
- **Framing error**
  - Stimulus: a stop bit of 0 on the 2nd data byte.
  - Required: `error`=1, `busy`=0, no further writes.
- **Reload while running**
  - Stimulus: in RUN, send 0x55, then 0xA5.
  - Required: 0x55 is ignored. On 0xA5, `core_reset`=1, `done`=0, `busy`=1, and the next load starts at addr 0.
